// File: rtl/writeback_pkg.sv
// Shared constants for the writeback/retire stage: opcode indices, FSM states
// and load funct3 encodings.
package writeback_pkg;

  localparam int unsigned OPCODE_WIDTH = 11;
  localparam int unsigned LOAD         = 0;
  localparam int unsigned SYSTEM       = 10;

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/lu_result_fifo.sv
// Synchronous FIFO with occupancy count for long-latency unit results.
module lu_result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign rdata = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/writeback_retire.sv
// Writeback/retire stage: merges pipeline results with buffered long-latency
// results, extracts load data, and sequences trap/mret redirects.
module writeback_retire
  import writeback_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LU_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_en,
  input  logic [OPCODE_WIDTH-1:0]   memory_opcode_type,
  input  logic [2:0]                memory_funct3,
  input  logic [1:0]                memory_addr_lo,
  input  logic [XLEN-1:0]           memory_data_load,
  input  logic [XLEN-1:0]           csr_data,
  input  logic                      memory_rd_wr_en,
  input  logic [4:0]                memory_rd,
  input  logic [XLEN-1:0]           memory_rd_wr_data,
  input  logic [XLEN-1:0]           memory_pc,
  input  logic                      go_to_trap,
  input  logic                      return_from_trap,
  input  logic [XLEN-1:0]           trap_addr,
  input  logic [XLEN-1:0]           return_addr,
  input  logic                      lu_valid,
  output logic                      lu_ready,
  input  logic [4:0]                lu_rd,
  input  logic [XLEN-1:0]           lu_data,
  output logic [$clog2(LU_DEPTH):0] lu_count,
  output logic                      writeback_rd_wr_en,
  output logic [4:0]                writeback_rd,
  output logic [XLEN-1:0]           writeback_rd_wr_data,
  output logic [XLEN-1:0]           writeback_pc,
  output logic                      writeback_change_pc,
  output logic                      next_stall,
  output logic                      next_flush
);

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      funct3,
                                                   input logic [1:0]      offset,
                                                   input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   return {{(XLEN-8){b[7]}}, b};
      F3_LBU:  return {{(XLEN-8){1'b0}}, b};
      F3_LH:   return {{(XLEN-16){h[15]}}, h};
      F3_LHU:  return {{(XLEN-16){1'b0}}, h};
      F3_LW:   return word;
      default: return word;
    endcase
  endfunction

  logic [0:0]      state_q, state_d;
  logic            wr_en_q, wr_en_d, change_pc_q, change_pc_d, flush_q, flush_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d, pc_q, pc_d, pipe_data;
  logic            redirect_take, slot_want, slot_taken, pop, push, fifo_full, fifo_empty;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic            unused_opcode;

  assign unused_opcode = ^memory_opcode_type;

  assign redirect_take = (state_q == RUN) && clk_en && (go_to_trap || return_from_trap);
  assign slot_want     = (state_q == RUN) && clk_en && memory_rd_wr_en && (memory_rd != 5'd0) &&
                         !go_to_trap && !return_from_trap;
  // A full FIFO steals the slot: stall upstream and drain one entry instead.
  assign next_stall    = fifo_full && slot_want;
  assign slot_taken    = slot_want && !next_stall;
  assign pop           = !slot_taken && !fifo_empty;
  assign lu_ready      = !fifo_full || pop;
  assign push          = lu_valid && lu_ready;

  lu_result_fifo #(
    .WIDTH (XLEN + 5),
    .DEPTH (LU_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({lu_rd, lu_data}),
    .rdata ({head_rd, head_data}),
    .count (lu_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    if (memory_opcode_type[LOAD]) begin
      pipe_data = load_extract(memory_funct3, memory_addr_lo, memory_data_load);
    end else if (memory_opcode_type[SYSTEM] && (memory_funct3 != 3'b000)) begin
      pipe_data = csr_data;
    end else begin
      pipe_data = memory_rd_wr_data;
    end
  end

  always_comb begin
    state_d     = RUN;
    wr_en_d     = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;
    pc_d        = memory_pc;
    change_pc_d = 1'b0;
    flush_d     = 1'b0;
    if (redirect_take) begin
      state_d     = REDIRECT;
      change_pc_d = 1'b1;
      flush_d     = 1'b1;
      pc_d        = go_to_trap ? trap_addr : return_addr;
    end
    if (slot_taken) begin
      wr_en_d = 1'b1;
      rd_d    = memory_rd;
      data_d  = pipe_data;
    end else if (pop) begin
      wr_en_d = (head_rd != 5'd0);
      rd_d    = head_rd;
      data_d  = head_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wr_en_q     <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      pc_q        <= '0;
      change_pc_q <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      pc_q        <= pc_d;
      change_pc_q <= change_pc_d;
      flush_q     <= flush_d;
    end
  end

  assign writeback_rd_wr_en   = wr_en_q;
  assign writeback_rd         = rd_q;
  assign writeback_rd_wr_data = data_q;
  assign writeback_pc         = pc_q;
  assign writeback_change_pc  = change_pc_q;
  assign next_flush           = flush_q;

endmodule

// File: tb/tb_writeback_retire.sv
// Directed plus randomized bench for writeback_retire against a queue-based model.
module tb_writeback_retire;
  import writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en;
  logic [OPCODE_WIDTH-1:0] memory_opcode_type;
  logic [2:0]  memory_funct3;
  logic [1:0]  memory_addr_lo;
  logic [31:0] memory_data_load, csr_data, memory_rd_wr_data, memory_pc;
  logic        memory_rd_wr_en;
  logic [4:0]  memory_rd;
  logic        go_to_trap, return_from_trap;
  logic [31:0] trap_addr, return_addr;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic [2:0]  lu_count;
  logic        writeback_rd_wr_en, writeback_change_pc, next_stall, next_flush;
  logic [4:0]  writeback_rd;
  logic [31:0] writeback_rd_wr_data, writeback_pc;

  always #5 clk = ~clk;

  writeback_retire #(.XLEN(32), .LU_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .memory_opcode_type(memory_opcode_type),
    .memory_funct3(memory_funct3), .memory_addr_lo(memory_addr_lo),
    .memory_data_load(memory_data_load), .csr_data(csr_data),
    .memory_rd_wr_en(memory_rd_wr_en), .memory_rd(memory_rd),
    .memory_rd_wr_data(memory_rd_wr_data), .memory_pc(memory_pc), .go_to_trap(go_to_trap),
    .return_from_trap(return_from_trap), .trap_addr(trap_addr), .return_addr(return_addr),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_count(lu_count), .writeback_rd_wr_en(writeback_rd_wr_en), .writeback_rd(writeback_rd),
    .writeback_rd_wr_data(writeback_rd_wr_data), .writeback_pc(writeback_pc),
    .writeback_change_pc(writeback_change_pc), .next_stall(next_stall), .next_flush(next_flush)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          in_redirect;
  logic        exp_wr, exp_chg;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data, exp_pc;
  int          checks = 0;
  int          errors = 0;

  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(1) << LOAD;
  localparam logic [OPCODE_WIDTH-1:0] OP_SYS   = OPCODE_WIDTH'(1) << SYSTEM;
  localparam logic [OPCODE_WIDTH-1:0] OP_ALU   = OPCODE_WIDTH'(1) << 7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] v;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_sel();
    if (memory_opcode_type[LOAD]) return ref_load(memory_funct3, memory_addr_lo, memory_data_load);
    if (memory_opcode_type[SYSTEM] && memory_funct3 != 3'b000) return csr_data;
    return memory_rd_wr_data;
  endfunction

  task automatic set_idle();
    clk_en = 0; memory_opcode_type = OP_ALU; memory_funct3 = 0; memory_addr_lo = 0;
    memory_data_load = 0; csr_data = 0; memory_rd_wr_en = 0; memory_rd = 0;
    memory_rd_wr_data = 0; go_to_trap = 0; return_from_trap = 0; trap_addr = 0;
    return_addr = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  task automatic set_pipe(input logic [OPCODE_WIDTH-1:0] op, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] val);
    clk_en = 1; memory_opcode_type = op; memory_funct3 = f3; memory_rd_wr_en = 1;
    memory_rd = rd; memory_rd_wr_data = val; memory_pc = memory_pc + 4;
  endtask

  // Called just after a negedge with inputs driven; returns at the following negedge.
  task automatic cycle();
    bit   run, redir, want, stall, slot, pop, ready;
    ent_t h;
    #1;
    run   = !in_redirect;
    redir = run && clk_en && (go_to_trap || return_from_trap);
    want  = run && clk_en && memory_rd_wr_en && memory_rd != 0 && !go_to_trap && !return_from_trap;
    stall = (q.size() == 4) && want;
    slot  = want && !stall;
    pop   = !slot && q.size() > 0;
    ready = q.size() < 4 || pop;
    check("lu_ready", 32'(lu_ready), 32'(ready));
    check("next_stall", 32'(next_stall), 32'(stall));
    if (slot) begin
      exp_wr = 1; exp_rd = memory_rd; exp_data = ref_sel();
    end else if (pop) begin
      h = q.pop_front();
      exp_wr = (h.rd != 0); exp_rd = h.rd; exp_data = h.data;
    end else begin
      exp_wr = 0;
    end
    if (lu_valid && ready) begin
      h.rd = lu_rd; h.data = lu_data;
      q.push_back(h);
    end
    exp_chg     = redir;
    exp_pc      = redir ? (go_to_trap ? trap_addr : return_addr) : memory_pc;
    in_redirect = redir;
    @(posedge clk);
    #1;
    check("wr_en", 32'(writeback_rd_wr_en), 32'(exp_wr));
    if (exp_wr) begin
      check("rd", 32'(writeback_rd), 32'(exp_rd));
      check("wr_data", writeback_rd_wr_data, exp_data);
    end
    check("pc", writeback_pc, exp_pc);
    check("change_pc", 32'(writeback_change_pc), 32'(exp_chg));
    check("flush", 32'(next_flush), 32'(exp_chg));
    check("lu_count", 32'(lu_count), 32'(q.size()));
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    memory_pc = 32'h1000;
    in_redirect = 0;
    #12;
    check("rst_wr_en", 32'(writeback_rd_wr_en), 0);
    check("rst_rd", 32'(writeback_rd), 0);
    check("rst_data", writeback_rd_wr_data, 0);
    check("rst_pc", writeback_pc, 0);
    check("rst_change_pc", 32'(writeback_change_pc), 0);
    check("rst_flush", 32'(next_flush), 0);
    check("rst_lu_count", 32'(lu_count), 0);
    check("rst_lu_ready", 32'(lu_ready), 1);
    @(negedge clk);
    rst_n = 1;

    // Load extraction
    set_pipe(OP_LOAD, 3'b000, 5'd5, 32'h0);
    memory_data_load = 32'h8070_F0A5; memory_addr_lo = 2'd1;
    cycle();
    check("lb_const", writeback_rd_wr_data, 32'hFFFF_FFF0);
    memory_funct3 = 3'b101; memory_addr_lo = 2'd2; memory_pc = memory_pc + 4;
    cycle();
    check("lhu_const", writeback_rd_wr_data, 32'h0000_8070);

    // CSR and plain SYSTEM
    set_pipe(OP_SYS, 3'b001, 5'd9, 32'hDEAD_0000);
    csr_data = 32'h1234;
    cycle();
    check("csr_const", writeback_rd_wr_data, 32'h1234);
    set_pipe(OP_SYS, 3'b000, 5'd9, 32'hCAFE);
    cycle();
    check("sys_plain_const", writeback_rd_wr_data, 32'hCAFE);

    // Trap while a load is present, then one suppressed cycle, then resume
    set_pipe(OP_LOAD, 3'b010, 5'd3, 32'h0);
    go_to_trap = 1; trap_addr = 32'h100;
    cycle();
    check("trap_pc_const", writeback_pc, 32'h100);
    go_to_trap = 0; memory_pc = memory_pc + 4;
    cycle();
    check("redirect_no_write", 32'(writeback_rd_wr_en), 0);
    memory_pc = memory_pc + 4;
    cycle();
    check("resume_write", 32'(writeback_rd_wr_en), 1);

    // Trap and mret together: trap wins
    set_pipe(OP_ALU, 3'b000, 5'd4, 32'h55);
    go_to_trap = 1; return_from_trap = 1; trap_addr = 32'h200; return_addr = 32'h300;
    cycle();
    check("trap_prio_const", writeback_pc, 32'h200);
    set_idle();
    cycle();

    // Fill FIFO while the pipeline writes every cycle, then stall and drain
    for (int i = 1; i <= 4; i++) begin
      set_pipe(OP_ALU, 3'b000, 5'd7, 32'h700 + 32'(i));
      lu_valid = 1; lu_rd = 5'(i); lu_data = 32'hA000 + 32'(i);
      cycle();
    end
    lu_valid = 0;
    memory_pc = memory_pc + 4;
    cycle();
    check("stall_drain_rd", 32'(writeback_rd), 1);
    check("stall_drain_data", writeback_rd_wr_data, 32'hA001);
    check("stall_count", 32'(lu_count), 3);

    // Asynchronous reset with entries pending
    #2 rst_n = 0;
    #1;
    check("async_rst_count", 32'(lu_count), 0);
    check("async_rst_wr_en", 32'(writeback_rd_wr_en), 0);
    q.delete(); in_redirect = 0;
    @(negedge clk);
    set_idle();
    rst_n = 1;
    cycle();
    cycle();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      int unsigned r;
      r = $urandom_range(0, 2);
      clk_en = ($urandom_range(0, 9) < 7);
      memory_opcode_type = (r == 0) ? OP_LOAD : (r == 1) ? OP_SYS : OP_ALU;
      memory_funct3 = 3'($urandom);
      memory_addr_lo = 2'($urandom);
      memory_data_load = $urandom;
      csr_data = $urandom;
      memory_rd_wr_data = $urandom;
      memory_rd_wr_en = ($urandom_range(0, 3) != 0);
      memory_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      memory_pc = $urandom;
      go_to_trap = ($urandom_range(0, 19) == 0);
      return_from_trap = ($urandom_range(0, 19) == 0);
      trap_addr = $urandom;
      return_addr = $urandom;
      lu_valid = ($urandom_range(0, 1) == 1);
      lu_rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      lu_data = $urandom;
      cycle();
    end

    set_idle();
    for (int k = 0; k < 8; k++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
